// File: rtl/dma_pkg.sv
// dma_pkg: shared types for the DMA burst scheduler and its AXI interface.
// Rev 1.0
`default_nettype none

package dma_pkg;

  localparam int DMA_ADDR_W     = 32;
  localparam int DMA_DATA_BYTES = 64;

  typedef enum logic [2:0] {
    DMA_NO_ERR,
    DMA_AXI_RD_ERR,
    DMA_AXI_WR_ERR,
    DMA_CFG_ERR,
    DMA_ABORT
  } e_dma_err_src_t;

  typedef struct packed {
    logic                  valid;
    e_dma_err_src_t        src;
    logic [DMA_ADDR_W-1:0] addr;
  } s_dma_error_t;

  typedef struct packed {
    logic                      valid;
    logic [DMA_ADDR_W-1:0]     addr;
    logic [7:0]                alen;
    logic [2:0]                size;
    logic [DMA_DATA_BYTES-1:0] strb;
    logic                      half_trans_valid;
  } s_dma_axi_req_t;

  typedef struct packed {
    logic ready;
  } s_dma_axi_resp_t;

  typedef enum logic [2:0] {IDLE, CHECK, RUN, DRAIN, DONE, ERR} e_sched_st_t;

  typedef struct packed {
    logic [DMA_ADDR_W-1:0] addr;
    logic [DMA_ADDR_W-1:0] beats_left;
  } s_burst_gen_t;

endpackage

`default_nettype wire

// File: rtl/dma_burst_gen.sv
// dma_burst_gen: splits one direction of a copy into boundary-safe INCR bursts.
// Rev 1.0
`default_nettype none

module dma_burst_gen
  import dma_pkg::*;
#(
  parameter int ADDR_W     = DMA_ADDR_W,
  parameter int DATA_BYTES = DMA_DATA_BYTES,
  parameter int MAX_BEATS  = 16,
  parameter int BOUNDARY   = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              kill,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] start_beats,
  output s_dma_axi_req_t    req,
  input  s_dma_axi_resp_t   resp,
  output logic              idle
);

  localparam int             BW    = ADDR_W + 1;
  localparam int             SIZE  = $clog2(DATA_BYTES);
  localparam logic [BW-1:0]  MAX_B = BW'(MAX_BEATS);
  localparam logic [BW-1:0]  BOUND = BW'(BOUNDARY);
  localparam logic [BW-1:0]  DB    = BW'(DATA_BYTES);

  s_burst_gen_t      st;
  logic              run;
  logic              valid;
  logic [BW-1:0]     bnd_beats;
  logic [BW-1:0]     beats;
  logic [BW-1:0]     next_left;
  logic [ADDR_W-1:0] step;

  always_comb begin
    bnd_beats = (BOUND - ({1'b0, st.addr} % BOUND)) / DB;
    beats     = MAX_B;
    if ({1'b0, st.beats_left} < beats) beats = {1'b0, st.beats_left};
    if (bnd_beats < beats)             beats = bnd_beats;
    step      = beats[ADDR_W-1:0] << SIZE;
    next_left = {1'b0, st.beats_left} - beats;
  end

  always_comb begin
    req.valid            = valid;
    req.addr             = st.addr;
    req.alen             = 8'(beats - BW'(1));
    req.size             = 3'(SIZE);
    req.strb             = '1;
    req.half_trans_valid = 1'b0;
  end

  assign idle = !run && !valid;

  // run marks a loaded descriptor; valid rises one cycle after start so the
  // first burst comes from registered addr/beats_left.
  always_ff @(posedge clk) begin
    if (rst) begin
      st    <= '0;
      run   <= 1'b0;
      valid <= 1'b0;
    end else if (kill) begin
      run   <= 1'b0;
      valid <= 1'b0;
    end else if (start) begin
      st.addr       <= start_addr;
      st.beats_left <= start_beats;
      run           <= 1'b1;
      valid         <= 1'b0;
    end else if (valid && resp.ready) begin
      st.addr       <= st.addr + step;
      st.beats_left <= next_left[ADDR_W-1:0];
      if (next_left == '0) begin
        valid <= 1'b0;
        run   <= 1'b0;
      end
    end else if (run) begin
      valid <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dma_burst_sched.sv
// dma_burst_sched: descriptor FSM, config checks and error latch over two burst generators.
// Rev 1.0
`default_nettype none

module dma_burst_sched
  import dma_pkg::*;
#(
  parameter int ADDR_W     = DMA_ADDR_W,
  parameter int DATA_BYTES = DMA_DATA_BYTES,
  parameter int MAX_BEATS  = 16,
  parameter int BOUNDARY   = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              desc_valid_i,
  output logic              desc_ready_o,
  input  logic [ADDR_W-1:0] desc_src_i,
  input  logic [ADDR_W-1:0] desc_dst_i,
  input  logic [ADDR_W-1:0] desc_bytes_i,
  output s_dma_axi_req_t    dma_axi_rd_req_o,
  input  s_dma_axi_resp_t   dma_axi_rd_resp_i,
  output s_dma_axi_req_t    dma_axi_wr_req_o,
  input  s_dma_axi_resp_t   dma_axi_wr_resp_i,
  input  logic              axi_pend_txn_i,
  input  s_dma_error_t      axi_dma_err_i,
  output logic              dma_active_o,
  output logic              clear_dma_o,
  output logic              done_o,
  output s_dma_error_t      err_o,
  input  logic              abort_i
);

  localparam int OFS = $clog2(DATA_BYTES);

  e_sched_st_t       state;
  logic [ADDR_W-1:0] src, dst, bytes;
  logic [ADDR_W:0]   src_end, dst_end;
  logic              src_bad, dst_bad, bytes_bad, src_wrap, dst_wrap, cfg_bad;
  logic [ADDR_W-1:0] cfg_addr, beats;
  logic              start, kill, rd_idle, wr_idle;

  // A transfer may end exactly at 2^ADDR_W but must not run past it.
  always_comb begin
    src_bad   = |src[OFS-1:0];
    dst_bad   = |dst[OFS-1:0];
    bytes_bad = (|bytes[OFS-1:0]) || (bytes == '0);
    src_end   = {1'b0, src} + {1'b0, bytes};
    dst_end   = {1'b0, dst} + {1'b0, bytes};
    src_wrap  = src_end[ADDR_W] && (|src_end[ADDR_W-1:0]);
    dst_wrap  = dst_end[ADDR_W] && (|dst_end[ADDR_W-1:0]);
    cfg_bad   = src_bad || dst_bad || bytes_bad || src_wrap || dst_wrap;
    if (src_bad)                     cfg_addr = src;
    else if (dst_bad)                cfg_addr = dst;
    else if (bytes_bad || src_wrap)  cfg_addr = src;
    else                             cfg_addr = dst;
  end

  assign beats = bytes >> OFS;
  assign start = (state == CHECK) && !cfg_bad;
  assign kill  = ((state == RUN) || (state == DRAIN)) && (axi_dma_err_i.valid || abort_i);

  dma_burst_gen #(
    .ADDR_W(ADDR_W), .DATA_BYTES(DATA_BYTES), .MAX_BEATS(MAX_BEATS), .BOUNDARY(BOUNDARY)
  ) u_rd_gen (
    .clk(clk), .rst(rst), .start(start), .kill(kill),
    .start_addr(src), .start_beats(beats),
    .req(dma_axi_rd_req_o), .resp(dma_axi_rd_resp_i), .idle(rd_idle)
  );

  dma_burst_gen #(
    .ADDR_W(ADDR_W), .DATA_BYTES(DATA_BYTES), .MAX_BEATS(MAX_BEATS), .BOUNDARY(BOUNDARY)
  ) u_wr_gen (
    .clk(clk), .rst(rst), .start(start), .kill(kill),
    .start_addr(dst), .start_beats(beats),
    .req(dma_axi_wr_req_o), .resp(dma_axi_wr_resp_i), .idle(wr_idle)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      desc_ready_o <= 1'b0;
      dma_active_o <= 1'b0;
      clear_dma_o  <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= '0;
      src          <= '0;
      dst          <= '0;
      bytes        <= '0;
    end else begin
      clear_dma_o <= 1'b0;
      done_o      <= 1'b0;
      case (state)
        IDLE: begin
          err_o        <= '0;
          desc_ready_o <= 1'b1;
          if (desc_valid_i && desc_ready_o) begin
            src          <= desc_src_i;
            dst          <= desc_dst_i;
            bytes        <= desc_bytes_i;
            desc_ready_o <= 1'b0;
            state        <= CHECK;
          end
        end
        CHECK: begin
          if (cfg_bad) begin
            err_o <= '{valid: 1'b1, src: DMA_CFG_ERR, addr: cfg_addr};
            state <= ERR;
          end else begin
            dma_active_o <= 1'b1;
            state        <= RUN;
          end
        end
        RUN, DRAIN: begin
          if (axi_dma_err_i.valid) begin
            err_o        <= axi_dma_err_i;
            dma_active_o <= 1'b0;
            state        <= ERR;
          end else if (abort_i) begin
            err_o        <= '{valid: 1'b1, src: DMA_ABORT, addr: '0};
            dma_active_o <= 1'b0;
            state        <= ERR;
          end else if (state == RUN) begin
            if (rd_idle && wr_idle) state <= DRAIN;
          end else if (!axi_pend_txn_i) begin
            done_o       <= 1'b1;
            dma_active_o <= 1'b0;
            state        <= DONE;
          end
        end
        DONE: begin
          clear_dma_o  <= 1'b1;
          desc_ready_o <= 1'b1;
          state        <= IDLE;
        end
        ERR: begin
          if (!axi_pend_txn_i) begin
            clear_dma_o  <= 1'b1;
            desc_ready_o <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
